// File: rtl/handshake_rr_arbiter.sv
// Round-robin N-to-1 arbiter feeding a registered 2-entry skid stage.
// A multi-beat packet keeps the grant until its last beat has been accepted.
// The upstream ready comes only from registered skid occupancy, so there is
// no combinational path from s_ready to m_ready.
module handshake_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    m_valid,
    input  logic [N*DW-1:0] m_data,
    input  logic [N-1:0]    m_last,
    output logic [N-1:0]    m_ready,
    output logic            s_valid,
    output logic [DW-1:0]   s_data,
    output logic [IW-1:0]   s_id,
    output logic            s_last,
    input  logic            s_ready
);

    localparam logic StIdle   = 1'b0;
    localparam logic StLocked = 1'b1;

    logic          state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] lock_q, lock_d;

    logic          s_valid_q, s_valid_d;
    logic [DW-1:0] s_data_q;
    logic [IW-1:0] s_id_q;
    logic          s_last_q;

    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q;
    logic [IW-1:0] skid_id_q;
    logic          skid_last_q;

    logic [IW-1:0] grant;
    logic          grant_found;
    logic [IW-1:0] sel;
    logic          sel_valid;
    logic          can_accept;
    logic          accept;
    logic [DW-1:0] beat_data;
    logic          beat_last;
    logic          load_main_beat, load_main_skid, load_skid;

    // Find the first valid requester after rr_ptr, wrapping modulo N.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(rr_ptr_q) + k) % N;
            if (!grant_found && m_valid[idx]) begin
                grant       = IW'(idx);
                grant_found = 1'b1;
            end
        end
    end

    // Select the granted requester; a locked packet holds its grant even when its valid drops.
    always_comb begin
        can_accept = ~skid_valid_q;
        sel        = (state_q == StLocked) ? lock_q : grant;
        sel_valid  = (state_q == StLocked) ? 1'b1 : grant_found;
        m_ready    = '0;
        if (!rst && sel_valid && can_accept) begin
            m_ready[sel] = 1'b1;
        end
        accept    = |(m_valid & m_ready);
        beat_data = m_data[sel*DW +: DW];
        beat_last = m_last[sel];
    end

    // Arbitration FSM: the pointer moves only when a packet completes.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        if (accept) begin
            if (beat_last) begin
                state_d  = StIdle;
                rr_ptr_d = sel;
            end else begin
                state_d = StLocked;
                lock_d  = sel;
            end
        end
    end

    // Skid-stage control: main register drives the slave, skid catches a beat during a stall.
    always_comb begin
        s_valid_d      = s_valid_q;
        skid_valid_d   = skid_valid_q;
        load_main_beat = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (skid_valid_q) begin
            if (s_ready) begin
                load_main_skid = 1'b1;
                skid_valid_d   = 1'b0;
            end
        end else if (accept) begin
            if (!s_valid_q || s_ready) begin
                load_main_beat = 1'b1;
                s_valid_d      = 1'b1;
            end else begin
                load_skid    = 1'b1;
                skid_valid_d = 1'b1;
            end
        end else if (s_valid_q && s_ready) begin
            s_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= IW'(N - 1);
            lock_q       <= '0;
            s_valid_q    <= 1'b0;
            s_data_q     <= '0;
            s_id_q       <= '0;
            s_last_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_id_q    <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            s_valid_q    <= s_valid_d;
            skid_valid_q <= skid_valid_d;
            if (load_main_beat) begin
                s_data_q <= beat_data;
                s_id_q   <= sel;
                s_last_q <= beat_last;
            end else if (load_main_skid) begin
                s_data_q <= skid_data_q;
                s_id_q   <= skid_id_q;
                s_last_q <= skid_last_q;
            end
            if (load_skid) begin
                skid_data_q <= beat_data;
                skid_id_q   <= sel;
                skid_last_q <= beat_last;
            end
        end
    end

    assign s_valid = s_valid_q;
    assign s_data  = s_data_q;
    assign s_id    = s_id_q;
    assign s_last  = s_last_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: directed vector table, a hand-written
// reset-while-locked sequence, and a randomized run against a queue model.
module tb_handshake_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_valid;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]    m_last;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic [IW-1:0]   s_id;
    logic            s_last;
    logic            s_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    handshake_rr_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_id    (s_id),
        .s_last  (s_last),
        .s_ready (s_ready)
    );

    typedef struct {
        logic          rst;
        logic [N-1:0]  mv;
        logic [N-1:0]  ml;
        logic          sr;
        logic [N-1:0]  emr;
        logic          esv;
        logic [IW-1:0] eid;
        logic          esl;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic          l;
    } beat_t;

    vec_t  vecs[$];
    beat_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic [N-1:0] mv, input logic [N-1:0] ml,
                                input logic sr, input logic [N-1:0] emr, input logic esv,
                                input logic [IW-1:0] eid, input logic esl);
        vec_t v;
        v.rst = r; v.mv = mv; v.ml = ml; v.sr = sr;
        v.emr = emr; v.esv = esv; v.eid = eid; v.esl = esl;
        vecs.push_back(v);
    endfunction

    // Random-phase state
    int unsigned seq[N];
    int unsigned rseq[N];
    int unsigned len_left[N];
    bit          locked;
    int unsigned ptr, lk, sel, idx;
    bit          have, can;
    logic [N-1:0] emr, hs;
    int          delivered, cyc;
    beat_t       b;

    initial begin
        // Reset / single-beat rotation / stall with skid full
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 2, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 3, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 1);
        add(0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 1, 1);
        add(0, 4'b1111, 4'b1111, 0, 4'b0000, 1, 1, 1);
        add(0, 4'b1111, 4'b1111, 0, 4'b0000, 1, 1, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0000, 1, 1, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 2, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 3, 1);
        // Reset, then a 3-beat packet from requester 2 with a valid gap mid-packet
        add(1, 4'b0000, 4'b1111, 1, 4'b0000, 1, 0, 1);
        add(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0010, 4'b1111, 1, 4'b0010, 0, 0, 0);
        add(0, 4'b1111, 4'b1011, 1, 4'b0100, 1, 1, 1);
        add(0, 4'b1011, 4'b1011, 1, 4'b0100, 1, 2, 0);
        add(0, 4'b1111, 4'b1011, 1, 4'b0100, 0, 0, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2, 0);
        add(0, 4'b1011, 4'b1111, 1, 4'b1000, 1, 2, 1);
        add(0, 4'b1011, 4'b1111, 1, 4'b0001, 1, 3, 1);
        add(0, 4'b1011, 4'b1111, 1, 4'b0010, 1, 0, 1);
        add(0, 4'b1011, 4'b1111, 1, 4'b1000, 1, 1, 1);

        for (int i = 0; i < N; i++) m_data[i*DW +: DW] = 32'hA0 + i;
        rst = 1'b1; m_valid = '1; m_last = '1; s_ready = 1'b1;
        tick();

        for (int r = 0; r < vecs.size(); r++) begin
            rst = vecs[r].rst; m_valid = vecs[r].mv; m_last = vecs[r].ml; s_ready = vecs[r].sr;
            @(negedge clk);
            chk($sformatf("vec%0d m_ready", r), m_ready, vecs[r].emr);
            chk($sformatf("vec%0d s_valid", r), s_valid, vecs[r].esv);
            if (vecs[r].esv) begin
                chk($sformatf("vec%0d s_id", r), s_id, vecs[r].eid);
                chk($sformatf("vec%0d s_last", r), s_last, vecs[r].esl);
                chk($sformatf("vec%0d s_data", r), s_data, 32'hA0 + vecs[r].eid);
            end
            tick();
        end

        // Reset while locked on requester 1 with the skid full
        rst = 1'b1; m_valid = '0; m_last = '0; s_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; m_valid = 4'b0010;
        @(negedge clk); chk("rstlock first ready", m_ready, 4'b0010); tick();
        @(negedge clk); chk("rstlock second ready", m_ready, 4'b0010); tick();
        @(negedge clk); chk("rstlock skid full ready", m_ready, 4'b0000);
        chk("rstlock s_valid held", s_valid, 1'b1);
        chk("rstlock s_id held", s_id, 2'd1);
        tick();
        rst = 1'b1; m_valid = 4'b1111;
        @(negedge clk); chk("rstlock ready in reset", m_ready, 4'b0000); tick();
        rst = 1'b0; m_last = 4'b1111; s_ready = 1'b1;
        @(negedge clk);
        chk("rstlock s_valid cleared", s_valid, 1'b0);
        chk("rstlock restart grant", m_ready, 4'b0001);
        tick();
        @(negedge clk);
        chk("rstlock first out id", s_id, 2'd0);
        chk("rstlock first out data", s_data, 32'hA0);
        tick();

        // Randomized run against a 2-deep queue model of the output stage
        rst = 1'b1; m_valid = '0; m_last = '0; s_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin seq[i] = 0; rseq[i] = 0; len_left[i] = 0; end
        locked = 0; ptr = N - 1; lk = 0; delivered = 0; cyc = 0;
        while (delivered < 1000 && cyc < 20000 && failures < 40) begin
            for (int i = 0; i < N; i++) begin
                if (!m_valid[i] && $urandom_range(0, 99) < 60) begin
                    if (len_left[i] == 0) len_left[i] = $urandom_range(1, 3);
                    m_valid[i] = 1'b1;
                    m_data[i*DW +: DW] = {4'(i), 28'(seq[i])};
                    m_last[i] = (len_left[i] == 1);
                end
            end
            s_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            can = (mq.size() < 2);
            emr = '0; sel = 0; have = 0;
            if (locked) begin
                sel = lk; have = 1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    idx = (ptr + k) % N;
                    if (!have && m_valid[idx]) begin sel = idx; have = 1; end
                end
            end
            if (have && can) emr[sel] = 1'b1;
            chk("rand m_ready", m_ready, emr);
            chk("rand s_valid", s_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("rand s_data", s_data, mq[0].d);
                chk("rand s_id", s_id, mq[0].id);
                chk("rand s_last", s_last, mq[0].l);
            end
            if (s_valid === 1'b1 && s_ready) begin
                chk("rand per-requester order", s_data, {4'(s_id), 28'(rseq[s_id])});
                rseq[s_id]++;
                delivered++;
            end
            if (mq.size() > 0 && s_ready) void'(mq.pop_front());
            if (have && can && m_valid[sel]) begin
                b.d = m_data[sel*DW +: DW]; b.id = IW'(sel); b.l = m_last[sel];
                mq.push_back(b);
                if (b.l) begin locked = 0; ptr = sel; end
                else begin locked = 1; lk = sel; end
            end
            hs = m_valid & m_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin m_valid[i] = 1'b0; seq[i]++; len_left[i]--; end
            end
            cyc++;
        end
        chk("rand beats delivered", delivered >= 1000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
